// File: rtl/axis_4to1_sched.sv
// axis_4to1_sched: packet-granular weighted round-robin scheduler for the 4:1
// AXI-Stream merge switch. Only one source is left unsuppressed at a time; the
// merged master handshake (tvalid/tready/tlast/tid) marks packet boundaries.
//
// Handshake: a beat is counted on a cycle where m_tvalid & m_tready are both
// high at the rising clki edge; a beat with m_tlast high is end-of-packet.
// Neither side is back-pressured by this block; it only observes.
//
// Optional build macro AXIS_SCHED_WDOG_EN adds a stall watchdog (parameter
// WDOG_CYC, output wdog_hit) that reclaims a grant whose packet stops moving.
module axis_4to1_sched #(
  parameter int WEIGHT_W = 4
`ifdef AXIS_SCHED_WDOG_EN
  , parameter int WDOG_CYC = 1024
`endif
) (
  input  logic                  clki,
  input  logic                  rsti,
  input  logic [3:0]            s_req,
  input  logic [4*WEIGHT_W-1:0] cfg_weight,
  input  logic                  m_tvalid,
  input  logic                  m_tready,
  input  logic                  m_tlast,
  input  logic [1:0]            m_tid,
  output logic [3:0]            arb_suppress,
  output logic                  grant_vld,
  output logic [1:0]            grant_id,
  output logic                  busy,
  output logic                  err_tid,
`ifdef AXIS_SCHED_WDOG_EN
  output logic                  wdog_hit,
`endif
  output logic                  dbg_state
);

  typedef enum logic {ST_ARB = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [1:0]          r_ptr;
  logic [1:0]          r_grant_id;
  logic [WEIGHT_W-1:0] r_credit;
  logic                r_busy;
  logic                r_err_tid;

  logic                w_beat;
  logic                w_tid_match;
  logic                w_beat_own;
  logic                w_beat_foreign;
  logic                w_eop_own;
  logic                w_req_drop;
  logic [3:0]          w_elig;
  logic                w_any_elig;
  logic                w_cont;
  logic [1:0]          w_pick;
  logic [1:0]          w_scan_idx;
  logic                w_found;
  logic [WEIGHT_W-1:0] w_pick_weight;
  logic                w_wdog_fire;

  // Handshake decode; beats only matter while a grant is active.
  assign w_beat         = m_tvalid & m_tready;
  assign w_tid_match    = (m_tid == r_grant_id);
  assign w_beat_own     = (r_state == ST_GRANT) & w_beat & w_tid_match;
  assign w_beat_foreign = (r_state == ST_GRANT) & w_beat & ~w_tid_match;
  assign w_eop_own      = w_beat_own & m_tlast;
  assign w_req_drop     = (r_state == ST_GRANT) & ~s_req[r_grant_id] & ~r_busy;

  // Eligibility: requesting and not disabled by a zero weight.
  always_comb begin
    w_elig = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_elig[i] = s_req[i] & (cfg_weight[i*WEIGHT_W +: WEIGHT_W] != '0);
    end
  end

  assign w_any_elig = |w_elig;
  // Remaining credit keeps the same port for another packet.
  assign w_cont     = (r_credit != '0) & w_elig[r_grant_id];

  // Rotating scan starting at the pointer, first eligible port wins.
  always_comb begin
    w_pick     = r_ptr;
    w_found    = 1'b0;
    w_scan_idx = r_ptr;
    for (int k = 0; k < 4; k++) begin
      w_scan_idx = r_ptr + k[1:0];
      if (!w_found && w_elig[w_scan_idx]) begin
        w_pick  = w_scan_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_pick_weight = cfg_weight[int'(w_pick)*WEIGHT_W +: WEIGHT_W];

`ifdef AXIS_SCHED_WDOG_EN
  localparam int CW = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
  localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_CYC - 1);

  logic [CW-1:0] r_wdog_cnt;
  logic          r_wdog_hit;

  assign w_wdog_fire = (r_state == ST_GRANT) & r_busy & ~w_beat &
                       (r_wdog_cnt == WDOG_LAST);

  // Stall counter: runs only mid-packet, restarts on any beat.
  always_ff @(posedge clki) begin
    if (rsti) begin
      r_wdog_cnt <= '0;
      r_wdog_hit <= 1'b0;
    end else begin
      r_wdog_hit <= w_wdog_fire;
      if ((r_state == ST_GRANT) && r_busy && !w_beat && !w_wdog_fire)
        r_wdog_cnt <= r_wdog_cnt + 1'b1;
      else
        r_wdog_cnt <= '0;
    end
  end

  assign wdog_hit = r_wdog_hit;
`else
  assign w_wdog_fire = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clki) begin
    if (rsti) r_state <= ST_ARB;
    else      r_state <= w_next_state;
  end

  // FSM next state: ARB decides in one cycle; GRANT ends on own eop or idle drop.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_ARB: begin
        if (w_cont || w_any_elig) w_next_state = ST_GRANT;
      end
      ST_GRANT: begin
        if (w_eop_own || w_req_drop || w_wdog_fire) w_next_state = ST_ARB;
      end
      default: w_next_state = ST_ARB;
    endcase
  end

  // FSM outputs: everyone blocked in ARB, only the granted port open in GRANT.
  always_comb begin
    arb_suppress = 4'b1111;
    grant_vld    = 1'b0;
    if (r_state == ST_GRANT) begin
      arb_suppress = ~(4'b0001 << r_grant_id);
      grant_vld    = 1'b1;
    end
  end

  // Grant bookkeeping: pick/credit/pointer, packet-in-flight flag, tid error.
  always_ff @(posedge clki) begin
    if (rsti) begin
      r_ptr      <= 2'd0;
      r_grant_id <= 2'd0;
      r_credit   <= '0;
      r_busy     <= 1'b0;
      r_err_tid  <= 1'b0;
    end else begin
      if ((r_state == ST_ARB) && !w_cont && w_any_elig) begin
        r_grant_id <= w_pick;
        r_credit   <= w_pick_weight;
        r_ptr      <= w_pick + 2'd1;
      end
      if (w_beat_foreign) r_err_tid <= 1'b1;
      if (w_eop_own) begin
        r_credit <= (r_credit != '0) ? r_credit - {{(WEIGHT_W-1){1'b0}}, 1'b1} : '0;
        r_busy   <= 1'b0;
      end else if (w_beat_own) begin
        r_busy <= 1'b1;
      end
      if (w_wdog_fire) begin
        r_credit <= '0;
        r_busy   <= 1'b0;
        r_ptr    <= r_grant_id + 2'd1;
      end
    end
  end

  assign grant_id  = r_grant_id;
  assign busy      = r_busy;
  assign err_tid   = r_err_tid;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_axis_4to1_sched.sv
// Directed bench for axis_4to1_sched: stimulus pushes the expected grant
// sequence into exp_q; a negedge monitor pops on every new grant.
module tb_axis_4to1_sched;
  localparam int WEIGHT_W = 4;

  logic                  clki = 1'b0;
  logic                  rsti;
  logic [3:0]            s_req;
  logic [4*WEIGHT_W-1:0] cfg_weight;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tlast;
  logic [1:0]            m_tid;
  logic [3:0]            arb_suppress;
  logic                  grant_vld;
  logic [1:0]            grant_id;
  logic                  busy;
  logic                  err_tid;
  logic                  dbg_state;
`ifdef AXIS_SCHED_WDOG_EN
  logic                  wdog_hit;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] exp_q[$];
  logic       prev_gv = 1'b0;

  // Clock and global time limit.
  always #5 clki = ~clki;

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

`ifdef AXIS_SCHED_WDOG_EN
  axis_4to1_sched #(.WEIGHT_W(WEIGHT_W), .WDOG_CYC(16)) dut (
`else
  axis_4to1_sched #(.WEIGHT_W(WEIGHT_W)) dut (
`endif
    .clki(clki), .rsti(rsti), .s_req(s_req), .cfg_weight(cfg_weight),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tid(m_tid),
    .arb_suppress(arb_suppress), .grant_vld(grant_vld), .grant_id(grant_id),
    .busy(busy), .err_tid(err_tid),
`ifdef AXIS_SCHED_WDOG_EN
    .wdog_hit(wdog_hit),
`endif
    .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each new grant must match the head of exp_q.
  always @(negedge clki) begin
    logic [1:0] e;
    logic [3:0] exp_sup;
    if (rsti) begin
      prev_gv = 1'b0;
    end else begin
      if (grant_vld && !prev_gv) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_grant: got id %0d, none expected at %0t", grant_id, $time);
        end else begin
          e = exp_q.pop_front();
          exp_sup = ~(4'b0001 << e);
          check("grant_id", 32'(grant_id), 32'(e));
          check("grant_suppress", 32'(arb_suppress), 32'(exp_sup));
        end
      end
      prev_gv = grant_vld;
    end
  end

  task automatic tick();
    @(posedge clki);
    #1;
  endtask

  task automatic do_reset();
    rsti = 1'b1;
    s_req = 4'b0000;
    m_tvalid = 1'b0;
    m_tlast = 1'b0;
    m_tid = 2'd0;
    tick();
    tick();
    rsti = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_suppress"}, 32'(arb_suppress), 32'hF);
    check({tag, "_gvld"}, 32'(grant_vld), 32'd0);
    check({tag, "_gid"}, 32'(grant_id), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err_tid), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic wait_grant();
    int n = 0;
    while (!grant_vld && n < 50) begin
      tick();
      n++;
    end
    if (!grant_vld) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_grant: grant_vld=%0d after %0d cycles, required 1", grant_vld, n);
    end
  endtask

  // One beat presented for a single cycle, then the bus goes idle.
  task automatic beat(input logic [1:0] tid, input logic last);
    m_tvalid = 1'b1;
    m_tready = 1'b1;
    m_tid = tid;
    m_tlast = last;
    tick();
    m_tvalid = 1'b0;
    m_tlast = 1'b0;
  endtask

  // Acts as the switch: one-beat packet from whoever is granted. Drops all
  // requests on the same cycle as the n-th eop. Checks the one-cycle bubble
  // after every eop and, if b2b, the regrant on the cycle after that.
  task automatic run_pkts(input int n, input bit b2b);
    int done = 0;
    int cyc = 0;
    int age = 0;
    bit eop_now;
    while (done < n && cyc < 300) begin
      eop_now = 1'b0;
      if (age == 1) begin
        check("bubble_gvld", 32'(grant_vld), 32'd0);
        check("bubble_suppress", 32'(arb_suppress), 32'hF);
      end
      if (age == 2 && b2b) check("regrant_latency", 32'(grant_vld), 32'd1);
      if (grant_vld) begin
        m_tvalid = 1'b1;
        m_tready = 1'b1;
        m_tlast = 1'b1;
        m_tid = grant_id;
        eop_now = 1'b1;
        done++;
        if (done == n) s_req = 4'b0000;
      end else begin
        m_tvalid = 1'b0;
      end
      tick();
      cyc++;
      if (eop_now) age = 1;
      else if (age > 0) age++;
    end
    m_tvalid = 1'b0;
    m_tlast = 1'b0;
    if (done < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_pkts_timeout: got %0d packets required %0d", done, n);
    end else begin
      check("final_bubble_gvld", 32'(grant_vld), 32'd0);
    end
  endtask

  initial begin
    m_tready = 1'b1;
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    do_reset();
    check_reset_vals("reset");

    // Idle: nobody requests, everything stays suppressed.
    s_req = 4'b0000;
    repeat (20) begin
      tick();
      check("idle_suppress", 32'(arb_suppress), 32'hF);
      check("idle_gvld", 32'(grant_vld), 32'd0);
    end

    // Equal weights: plain rotation 0,1,2,3,0.
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    s_req = 4'b1111;
    tick();
    check("req_latency", 32'(grant_vld), 32'd1);
    run_pkts(5, 1'b1);

    // Port 0 weight 3: 0,0,0,1,2,3,0,0,0.
    do_reset();
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd3};
    exp_q.push_back(2'd0); exp_q.push_back(2'd0); exp_q.push_back(2'd0);
    exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    exp_q.push_back(2'd0); exp_q.push_back(2'd0); exp_q.push_back(2'd0);
    s_req = 4'b1111;
    run_pkts(9, 1'b1);

    // Disabled port is never granted; enabling it with weight 2 gives 2,2.
    cfg_weight = {4'd1, 4'd0, 4'd1, 4'd1};
    s_req = 4'b0100;
    repeat (10) begin
      tick();
      check("disabled_gvld", 32'(grant_vld), 32'd0);
    end
    cfg_weight = {4'd1, 4'd2, 4'd1, 4'd1};
    exp_q.push_back(2'd2); exp_q.push_back(2'd2);
    tick();
    check("enable_latency", 32'(grant_vld), 32'd1);
    run_pkts(2, 1'b1);

    // Foreign tid: error flag, grant untouched, own eop ends the turn.
    do_reset();
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    exp_q.push_back(2'd1);
    s_req = 4'b0010;
    wait_grant();
    beat(2'd2, 1'b1);
    check("tid_err_set", 32'(err_tid), 32'd1);
    check("tid_err_gvld", 32'(grant_vld), 32'd1);
    check("tid_err_gid", 32'(grant_id), 32'd1);
    check("tid_err_busy", 32'(busy), 32'd0);
    beat(2'd1, 1'b0);
    check("own_beat_busy", 32'(busy), 32'd1);
    s_req = 4'b0000;
    tick();
    check("busy_holds_grant", 32'(grant_vld), 32'd1);
    beat(2'd1, 1'b1);
    check("own_eop_gvld", 32'(grant_vld), 32'd0);
    check("own_eop_busy", 32'(busy), 32'd0);
    tick();
    check("tid_err_sticky", 32'(err_tid), 32'd1);

    // Request drop while idle keeps credit: port 3 (weight 2) resumes first.
    do_reset();
    cfg_weight = {4'd2, 4'd1, 4'd1, 4'd1};
    exp_q.push_back(2'd3);
    s_req = 4'b1000;
    wait_grant();
    s_req = 4'b0000;
    tick();
    check("drop_to_arb", 32'(grant_vld), 32'd0);
    exp_q.push_back(2'd3); exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    s_req = 4'b1001;
    run_pkts(3, 1'b1);

    // Reset in the middle of a packet.
    exp_q.push_back(2'd0);
    s_req = 4'b0001;
    wait_grant();
    beat(2'd0, 1'b0);
    check("midpkt_busy", 32'(busy), 32'd1);
    rsti = 1'b1;
    tick();
    check_reset_vals("midpkt_reset");
    rsti = 1'b0;
    s_req = 4'b0000;
    tick();

`ifdef AXIS_SCHED_WDOG_EN
    // Stalled packet on port 0 is reclaimed after 16 idle cycles.
    begin
      int n = 0;
      do_reset();
      cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
      exp_q.push_back(2'd0);
      s_req = 4'b0011;
      wait_grant();
      beat(2'd0, 1'b0);
      while (!wdog_hit && n < 40) begin
        tick();
        n++;
      end
      check("wdog_cycles", 32'(n), 32'd16);
      check("wdog_gvld", 32'(grant_vld), 32'd0);
      exp_q.push_back(2'd1);
      tick();
      check("wdog_pulse_width", 32'(wdog_hit), 32'd0);
      run_pkts(1, 1'b0);
    end
`endif

    tick();
    tick();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_grants: got %0d left in queue, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
